// File: rtl/i2c_apb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_apb_regs
//  Description : APB3 register file for the I2C controller. Zero-wait-state
//                writes; reads take one wait state (RDW) with prdata and the
//                error flag registered. Write-1-to-clear interrupt status
//                with IER masking, registered irq, and a retriggerable
//                soft-reset pulse towards the core.
//  Ports       : clk, rstn (async, active low)
//                psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr: APB3
//                irq                      : registered interrupt
//                tx_fifo_* / rx_fifo_*    : FIFO push/pop and status
//                rx_pirq, slv_adr, cr, tim: configuration outputs to core
//                sr, irq_req              : status and interrupt set pulses
//                srstn                    : soft reset to core, active low
//  Revision    : 2.0 - APB3 handshake, W1C interrupts, soft-reset pulse
// ============================================================================
module i2c_apb_regs #(
  parameter int ADDR_W   = 12,
  parameter int OCY_W    = 5,
  parameter int N_IRQ    = 8,
  parameter int TW       = 16,
  parameter int TIM_RST  = 50,
  parameter int SRST_LEN = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq,
  input  logic [OCY_W-1:0]  tx_fifo_ocy,
  input  logic [OCY_W-1:0]  rx_fifo_ocy,
  input  logic              tx_fifo_full,
  input  logic              rx_fifo_empty,
  output logic              tx_fifo_wr,
  output logic [9:0]        tx_fifo_wdat,
  output logic              rx_fifo_rd,
  input  logic [7:0]        rx_fifo_rdat,
  output logic [4:0]        rx_pirq,
  output logic [9:0]        slv_adr,
  output logic              srstn,
  output logic [6:0]        cr,
  input  logic [7:0]        sr,
  input  logic [N_IRQ-1:0]  irq_req,
  output logic [8*TW-1:0]   tim
);

  localparam logic [8:0] c_off_gie  = 9'h01C;
  localparam logic [8:0] c_off_isr  = 9'h020;
  localparam logic [8:0] c_off_ier  = 9'h028;
  localparam logic [8:0] c_off_srst = 9'h040;
  localparam logic [8:0] c_off_cr   = 9'h100;
  localparam logic [8:0] c_off_sr   = 9'h104;
  localparam logic [8:0] c_off_txd  = 9'h108;
  localparam logic [8:0] c_off_rxd  = 9'h10C;
  localparam logic [8:0] c_off_adr  = 9'h110;
  localparam logic [8:0] c_off_txo  = 9'h114;
  localparam logic [8:0] c_off_rxo  = 9'h118;
  localparam logic [8:0] c_off_ten  = 9'h11C;
  localparam logic [8:0] c_off_pirq = 9'h120;
  localparam int         c_off_tim0 = 'h128;
  localparam int         c_cw       = $clog2(SRST_LEN + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RDW = 1'b1} state_t;

  state_t            r_state;
  logic              r_rd_err;
  logic              r_gie;
  logic [N_IRQ-1:0]  r_isr;
  logic [N_IRQ-1:0]  r_ier;
  logic [6:0]        r_cr;
  logic [6:0]        r_adr;
  logic [2:0]        r_ten;
  logic [4:0]        r_pirq;
  logic [TW-1:0]     r_tim [8];
  logic [c_cw-1:0]   r_cnt;
  logic              r_srstn;
  logic              r_irq;

  logic [8:0]        w_off;
  logic              w_hi_ok;
  logic              w_wr;
  logic              w_rd;
  logic              w_is_tim;
  logic [2:0]        w_tim_idx;
  logic              w_map_ok;
  logic              w_ro;
  logic              w_wo;
  logic [31:0]       w_rdata;
  logic              w_wr_err;
  logic              w_rd_err;
  logic              w_wr_ok;
  logic              w_key;
  logic [N_IRQ-1:0]  w_clr;
  logic [N_IRQ-1:0]  w_set;
  logic [c_cw-1:0]   w_cnt_next;

  assign w_off = paddr[8:0];
  assign w_wr  = psel & penable & pwrite;
  assign w_rd  = psel & penable & ~pwrite;

  // Address bits above the 9-bit decode window must be zero to hit the map.
  generate
    if (ADDR_W > 9) begin : g_hi
      assign w_hi_ok = ~|paddr[ADDR_W-1:9];
    end else begin : g_no_hi
      assign w_hi_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    w_is_tim  = 1'b0;
    w_tim_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_off == 9'(c_off_tim0 + 4 * i)) begin
        w_is_tim  = 1'b1;
        w_tim_idx = 3'(i);
      end
    end
  end

  // Decode classification and read-data mux.
  always_comb begin
    w_map_ok = 1'b1;
    w_ro     = 1'b0;
    w_wo     = 1'b0;
    w_rdata  = 32'd0;
    case (w_off)
      c_off_gie:  w_rdata = {31'd0, r_gie};
      c_off_isr:  w_rdata = 32'(r_isr);
      c_off_ier:  w_rdata = 32'(r_ier);
      c_off_srst: w_wo    = 1'b1;
      c_off_cr:   w_rdata = 32'(r_cr);
      c_off_sr:   begin w_ro = 1'b1; w_rdata = 32'(sr); end
      c_off_txd:  w_wo    = 1'b1;
      c_off_rxd:  begin w_ro = 1'b1; w_rdata = 32'(rx_fifo_rdat); end
      c_off_adr:  w_rdata = 32'({r_adr, 1'b0});
      c_off_txo:  begin w_ro = 1'b1; w_rdata = 32'(tx_fifo_ocy); end
      c_off_rxo:  begin w_ro = 1'b1; w_rdata = 32'(rx_fifo_ocy); end
      c_off_ten:  w_rdata = 32'(r_ten);
      c_off_pirq: w_rdata = 32'(r_pirq);
      default: begin
        w_map_ok = w_is_tim;
        w_rdata  = 32'(r_tim[w_tim_idx]);
      end
    endcase
    if (!w_hi_ok) begin
      w_map_ok = 1'b0;
    end
  end

  assign w_wr_err = ~w_map_ok | w_ro
                  | ((w_off == c_off_txd)  & tx_fifo_full)
                  | ((w_off == c_off_srst) & (pwdata != 32'h0000_000A));
  assign w_rd_err = ~w_map_ok | w_wo
                  | ((w_off == c_off_rxd) & rx_fifo_empty);

  assign w_wr_ok = w_wr & ~w_wr_err;
  assign w_key   = w_wr_ok & (w_off == c_off_srst);

  // Write error is answered in the same cycle (zero wait states); read error
  // is the flag captured on entry to RDW.
  assign pready  = w_wr | (r_state == S_RDW);
  assign pslverr = (w_wr & w_wr_err) | ((r_state == S_RDW) & r_rd_err);

  assign tx_fifo_wr   = w_wr_ok & (w_off == c_off_txd);
  assign tx_fifo_wdat = pwdata[9:0];

  assign w_clr = (w_wr_ok && (w_off == c_off_isr)) ? pwdata[N_IRQ-1:0] : '0;
  assign w_set = r_srstn ? irq_req : '0;

  // Counter reloads on every valid key write, so a rewrite extends the pulse.
  assign w_cnt_next = w_key ? c_cw'(SRST_LEN)
                    : ((r_cnt != '0) ? (r_cnt - c_cw'(1)) : '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      prdata     <= 32'd0;
      r_rd_err   <= 1'b0;
      rx_fifo_rd <= 1'b0;
    end else begin
      rx_fifo_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rd) begin
            r_state    <= S_RDW;
            r_rd_err   <= w_rd_err;
            prdata     <= w_rd_err ? 32'd0 : w_rdata;
            rx_fifo_rd <= ~w_rd_err & (w_off == c_off_rxd);
          end
        end
        S_RDW:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gie   <= 1'b0;
      r_isr   <= '0;
      r_ier   <= '0;
      r_cr    <= 7'd0;
      r_adr   <= 7'd0;
      r_ten   <= 3'd0;
      r_pirq  <= 5'd1;
      r_cnt   <= '0;
      r_srstn <= 1'b1;
      r_irq   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_tim[i] <= TW'(TIM_RST);
      end
    end else begin
      r_cnt   <= w_cnt_next;
      r_srstn <= (w_cnt_next == '0);
      r_irq   <= r_gie & |(r_isr & r_ier);

      // Entering soft reset wipes status and control; a new set pulse
      // otherwise wins over a same-cycle clear.
      if (w_key) begin
        r_isr <= '0;
      end else begin
        r_isr <= (r_isr & ~w_clr) | w_set;
      end

      if (w_key) begin
        r_cr <= 7'd0;
      end else if (w_wr_ok && (w_off == c_off_cr)) begin
        r_cr <= pwdata[6:0];
      end

      if (w_wr_ok && (w_off == c_off_gie))  r_gie  <= pwdata[0];
      if (w_wr_ok && (w_off == c_off_ier))  r_ier  <= pwdata[N_IRQ-1:0];
      if (w_wr_ok && (w_off == c_off_adr))  r_adr  <= pwdata[7:1];
      if (w_wr_ok && (w_off == c_off_ten))  r_ten  <= pwdata[2:0];
      if (w_wr_ok && (w_off == c_off_pirq)) r_pirq <= pwdata[4:0];

      for (int i = 0; i < 8; i++) begin
        if (w_wr_ok && w_is_tim && (w_tim_idx == 3'(i))) begin
          r_tim[i] <= pwdata[TW-1:0];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tim
      assign tim[gi*TW +: TW] = r_tim[gi];
    end
  endgenerate

  assign irq     = r_irq;
  assign srstn   = r_srstn;
  assign cr      = r_cr;
  assign rx_pirq = r_pirq;
  assign slv_adr = {r_ten, r_adr};

endmodule
`default_nettype wire

// File: tb/tb_i2c_apb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_apb_regs
//  Description : Self-checking bench for i2c_apb_regs. Directed steps plus a
//                randomized register phase compared against an address-keyed
//                register model (value & width mask, W1C rule for isr).
//  Revision    : 2.0
// ============================================================================
module tb_i2c_apb_regs;
  localparam int ADDR_W   = 12;
  localparam int OCY_W    = 5;
  localparam int N_IRQ    = 8;
  localparam int TW       = 16;
  localparam int TIM_RST  = 50;
  localparam int SRST_LEN = 10;

  logic              clk = 1'b0;
  logic              rstn;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready, pslverr, irq;
  logic [OCY_W-1:0]  tx_fifo_ocy, rx_fifo_ocy;
  logic              tx_fifo_full, rx_fifo_empty;
  logic              tx_fifo_wr;
  logic [9:0]        tx_fifo_wdat;
  logic              rx_fifo_rd;
  logic [7:0]        rx_fifo_rdat;
  logic [4:0]        rx_pirq;
  logic [9:0]        slv_adr;
  logic              srstn;
  logic [6:0]        cr;
  logic [7:0]        sr;
  logic [N_IRQ-1:0]  irq_req;
  logic [8*TW-1:0]   tim;

  i2c_apb_regs #(
    .ADDR_W(ADDR_W), .OCY_W(OCY_W), .N_IRQ(N_IRQ), .TW(TW),
    .TIM_RST(TIM_RST), .SRST_LEN(SRST_LEN)
  ) dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq), .tx_fifo_ocy(tx_fifo_ocy),
    .rx_fifo_ocy(rx_fifo_ocy), .tx_fifo_full(tx_fifo_full),
    .rx_fifo_empty(rx_fifo_empty), .tx_fifo_wr(tx_fifo_wr),
    .tx_fifo_wdat(tx_fifo_wdat), .rx_fifo_rd(rx_fifo_rd),
    .rx_fifo_rdat(rx_fifo_rdat), .rx_pirq(rx_pirq), .slv_adr(slv_adr),
    .srstn(srstn), .cr(cr), .sr(sr), .irq_req(irq_req), .tim(tim)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event counters, each written only by its own monitor.
  int tx_wr_total = 0;
  int rx_rd_total = 0;
  int low_total   = 0;
  always @(posedge clk) if (tx_fifo_wr === 1'b1) tx_wr_total++;
  always @(negedge clk) begin
    if (rx_fifo_rd === 1'b1) rx_rd_total++;
    if (srstn === 1'b0) low_total++;
  end

  // Reference model: every read/write register keyed by its byte offset.
  logic [31:0] m_reg  [int];
  logic [31:0] m_mask [int];
  int rw_list [15] = '{'h01C, 'h020, 'h028, 'h100, 'h110, 'h11C, 'h120,
                       'h128, 'h12C, 'h130, 'h134, 'h138, 'h13C, 'h140, 'h144};

  function automatic logic [31:0] lowmask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  task automatic model_reset();
    m_mask['h01C] = 32'h1;               m_reg['h01C] = 32'd0;
    m_mask['h020] = lowmask(N_IRQ);      m_reg['h020] = 32'd0;
    m_mask['h028] = lowmask(N_IRQ);      m_reg['h028] = 32'd0;
    m_mask['h100] = 32'h7F;              m_reg['h100] = 32'd0;
    m_mask['h110] = 32'hFE;              m_reg['h110] = 32'd0;
    m_mask['h11C] = 32'h7;               m_reg['h11C] = 32'd0;
    m_mask['h120] = 32'h1F;              m_reg['h120] = 32'd1;
    for (int i = 0; i < 8; i++) begin
      m_mask['h128 + 4*i] = lowmask(TW);
      m_reg['h128 + 4*i]  = 32'(TIM_RST);
    end
  endtask

  task automatic m_write(input int a, input logic [31:0] d);
    if (a == 'h020) m_reg[a] = m_reg[a] & ~(d & m_mask[a]);
    else            m_reg[a] = d & m_mask[a];
  endtask

  function automatic logic model_irq();
    return m_reg['h01C][0] & (|(m_reg['h020] & m_reg['h028]));
  endfunction

  function automatic logic [8*TW-1:0] model_tim();
    logic [8*TW-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*TW +: TW] = m_reg['h128 + 4*i][TW-1:0];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       s_txwr;
  logic [9:0] s_txd;

  task automatic apb_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [N_IRQ-1:0] req, output logic rdy, output logic err);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1; irq_req = req;
    #1;
    rdy = pready; err = pslverr; s_txwr = tx_fifo_wr; s_txd = tx_fifo_wdat;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; irq_req = '0;
  endtask

  task automatic apb_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                        output logic err, output logic wait_rdy, output logic rdy);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 wait_rdy = pready;
    @(negedge clk);
    #1;
    rdy = pready; d = prdata; err = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_srst_done();
    for (int i = 0; i < 200 && srstn !== 1'b1; i++) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er, w0, r1;
  int          snap, a;
  logic [31:0] d;
  logic [N_IRQ-1:0] req;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; tx_fifo_ocy = '0; rx_fifo_ocy = '0; tx_fifo_full = 1'b0;
    rx_fifo_empty = 1'b1; rx_fifo_rdat = '0; sr = '0; irq_req = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_prdata", 128'(prdata), 128'(0));
    chk("rst_pready", 128'(pready), 128'(0));
    chk("rst_pslverr", 128'(pslverr), 128'(0));
    chk("rst_irq", 128'(irq), 128'(0));
    chk("rst_srstn", 128'(srstn), 128'(1));
    chk("rst_cr", 128'(cr), 128'(0));
    chk("rst_pirq", 128'(rx_pirq), 128'(1));
    chk("rst_tim", 128'(tim), 128'(model_tim()));
    rstn = 1'b1;

    // First read: one wait state then timing reset value.
    apb_rd(12'h128, rd, er, w0, r1);
    chk("rd128_wait", 128'(w0), 128'(0));
    chk("rd128_rdy", 128'(r1), 128'(1));
    chk("rd128_data", 128'(rd), 128'(TIM_RST));
    chk("rd128_err", 128'(er), 128'(0));
    apb_rd(12'h120, rd, er, w0, r1);
    chk("rd120_data", 128'(rd), 128'(1));

    // TX push, then push into a full FIFO.
    snap = tx_wr_total;
    apb_wr(12'h108, 32'h3A5, '0, r1, er);
    chk("tx_rdy", 128'(r1), 128'(1));
    chk("tx_err", 128'(er), 128'(0));
    chk("tx_wr", 128'(s_txwr), 128'(1));
    chk("tx_wdat", 128'(s_txd), 128'(10'h3A5));
    chk("tx_pulses", 128'(tx_wr_total - snap), 128'(1));
    tx_fifo_full = 1'b1;
    snap = tx_wr_total;
    apb_wr(12'h108, 32'h3A5, '0, r1, er);
    chk("txfull_err", 128'(er), 128'(1));
    chk("txfull_pulses", 128'(tx_wr_total - snap), 128'(0));
    tx_fifo_full = 1'b0;

    // RX pop, then pop from an empty FIFO.
    rx_fifo_rdat = 8'h5C; rx_fifo_empty = 1'b0;
    snap = rx_rd_total;
    apb_rd(12'h10C, rd, er, w0, r1);
    @(negedge clk);
    chk("rx_data", 128'(rd), 128'(8'h5C));
    chk("rx_err", 128'(er), 128'(0));
    chk("rx_pulses", 128'(rx_rd_total - snap), 128'(1));
    rx_fifo_empty = 1'b1;
    snap = rx_rd_total;
    apb_rd(12'h10C, rd, er, w0, r1);
    @(negedge clk);
    chk("rxempty_err", 128'(er), 128'(1));
    chk("rxempty_data", 128'(rd), 128'(0));
    chk("rxempty_pulses", 128'(rx_rd_total - snap), 128'(0));

    // Read-only status registers with random inputs.
    sr = 8'($urandom); tx_fifo_ocy = OCY_W'($urandom); rx_fifo_ocy = OCY_W'($urandom);
    apb_rd(12'h104, rd, er, w0, r1);
    chk("sr_rd", 128'(rd), 128'(sr));
    apb_rd(12'h114, rd, er, w0, r1);
    chk("txocy_rd", 128'(rd), 128'(tx_fifo_ocy));
    apb_rd(12'h118, rd, er, w0, r1);
    chk("rxocy_rd", 128'(rd), 128'(rx_fifo_ocy));

    // Interrupt path.
    apb_wr(12'h01C, 32'h1, '0, r1, er);  m_write('h01C, 32'h1);
    apb_wr(12'h028, 32'h04, '0, r1, er); m_write('h028, 32'h04);
    repeat (2) @(negedge clk);
    chk("irq_idle", 128'(irq), 128'(0));
    irq_req = 8'h04;
    @(negedge clk);
    irq_req = '0;
    #1 chk("irq_lat0", 128'(irq), 128'(0));
    @(negedge clk);
    chk("irq_lat1", 128'(irq), 128'(1));
    m_reg['h020] |= 32'h04;
    apb_rd(12'h020, rd, er, w0, r1);
    chk("isr_04", 128'(rd), 128'(m_reg['h020]));
    apb_wr(12'h020, 32'h04, '0, r1, er); m_write('h020, 32'h04);
    repeat (2) @(negedge clk);
    chk("irq_clr", 128'(irq), 128'(0));
    irq_req = 8'h02;
    @(negedge clk);
    irq_req = '0;
    m_reg['h020] |= 32'h02;
    repeat (3) @(negedge clk);
    chk("irq_masked", 128'(irq), 128'(0));
    apb_wr(12'h020, 32'h04, 8'h04, r1, er);
    m_write('h020, 32'h04); m_reg['h020] |= 32'h04;
    apb_rd(12'h020, rd, er, w0, r1);
    chk("isr_setwins", 128'(rd), 128'(m_reg['h020]));

    // Randomized register traffic against the model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = rw_list[$urandom_range(0, 14)]; d = $urandom;
          apb_wr(12'(a), d, '0, r1, er);
          m_write(a, d);
          chk("rnd_wr_err", 128'(er), 128'(0));
        end
        1: begin
          d = $urandom; req = N_IRQ'($urandom);
          apb_wr(12'h020, d, req, r1, er);
          m_write('h020, d); m_reg['h020] |= 32'(req);
        end
        default: begin
          a = rw_list[$urandom_range(0, 14)];
          apb_rd(12'(a), rd, er, w0, r1);
          chk("rnd_rd", 128'(rd), 128'(m_reg[a]));
        end
      endcase
      repeat (2) @(negedge clk);
      chk("rnd_irq", 128'(irq), 128'(model_irq()));
    end
    chk("out_cr", 128'(cr), 128'(m_reg['h100][6:0]));
    chk("out_slv_adr", 128'(slv_adr), 128'({m_reg['h11C][2:0], m_reg['h110][7:1]}));
    chk("out_pirq", 128'(rx_pirq), 128'(m_reg['h120][4:0]));
    chk("out_tim", 128'(tim), 128'(model_tim()));

    // Soft reset: single pulse, then a retrigger five cycles in.
    apb_wr(12'h100, 32'h55, '0, r1, er); m_write('h100, 32'h55);
    snap = low_total;
    apb_wr(12'h040, 32'hA, '0, r1, er);
    chk("srst_err", 128'(er), 128'(0));
    chk("srst_low", 128'(srstn), 128'(0));
    m_reg['h100] = 0; m_reg['h020] = 0;
    wait_srst_done();
    chk("srst_done", 128'(srstn), 128'(1));
    chk("srst_len", 128'(low_total - snap), 128'(SRST_LEN));
    apb_rd(12'h100, rd, er, w0, r1);
    chk("srst_cr", 128'(rd), 128'(0));
    apb_rd(12'h028, rd, er, w0, r1);
    chk("srst_ier_kept", 128'(rd), 128'(m_reg['h028]));
    snap = low_total;
    apb_wr(12'h040, 32'hA, '0, r1, er);
    repeat (2) @(negedge clk);
    apb_wr(12'h040, 32'hA, '0, r1, er);
    irq_req = 8'h01;
    @(negedge clk);
    irq_req = '0;
    wait_srst_done();
    chk("srst_ext_len", 128'(low_total - snap), 128'(5 + SRST_LEN));
    apb_rd(12'h020, rd, er, w0, r1);
    chk("srst_irq_ign", 128'(rd), 128'(0));
    snap = low_total;
    apb_wr(12'h040, 32'hB, '0, r1, er);
    chk("badkey_err", 128'(er), 128'(1));
    repeat (3) @(negedge clk);
    chk("badkey_srstn", 128'(srstn), 128'(1));
    chk("badkey_nolow", 128'(low_total - snap), 128'(0));

    // Error responses.
    apb_rd(12'h0FC, rd, er, w0, r1);
    chk("unmap_rd_err", 128'(er), 128'(1));
    chk("unmap_rd_data", 128'(rd), 128'(0));
    apb_wr(12'h0FC, 32'hFFFF_FFFF, '0, r1, er);
    chk("unmap_wr_err", 128'(er), 128'(1));
    apb_wr(12'h104, 32'hFF, '0, r1, er);
    chk("ro_wr_err", 128'(er), 128'(1));
    apb_wr(12'h900, 32'h7F, '0, r1, er);
    chk("hiaddr_err", 128'(er), 128'(1));
    apb_rd(12'h100, rd, er, w0, r1);
    chk("hiaddr_nochg", 128'(rd), 128'(m_reg['h100]));
    apb_rd(12'h040, rd, er, w0, r1);
    chk("wo_rd_err", 128'(er), 128'(1));
    apb_rd(12'h108, rd, er, w0, r1);
    chk("wo_rd_data", 128'(rd), 128'(0));

    // Async reset while a read sits in RDW.
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 12'h128;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #1 chk("rdw_rdy", 128'(pready), 128'(1));
    rstn = 1'b0;
    #1 chk("rdw_abort", 128'(pready), 128'(0));
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    apb_rd(12'h128, rd, er, w0, r1);
    chk("post_wait", 128'(w0), 128'(0));
    chk("post_rdy", 128'(r1), 128'(1));
    chk("post_data", 128'(rd), 128'(m_reg['h128]));
    apb_rd(12'h01C, rd, er, w0, r1);
    chk("post_gie", 128'(rd), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
